// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph codes, active-high segment patterns and FSM states for the 7-segment display
package seg7_pkg;

  typedef enum logic [4:0] {
    GLYPH_0, GLYPH_1, GLYPH_2, GLYPH_3, GLYPH_4, GLYPH_5, GLYPH_6, GLYPH_7,
    GLYPH_8, GLYPH_9, GLYPH_A, GLYPH_B, GLYPH_C, GLYPH_D, GLYPH_E, GLYPH_F,
    GLYPH_DASH, GLYPH_BLANK
  } glyph_e;

  // Bit order is g..a, segment on = 1.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_A     = 7'b1110111;
  localparam logic [6:0] SEG_B     = 7'b1111100;
  localparam logic [6:0] SEG_C     = 7'b0111001;
  localparam logic [6:0] SEG_D     = 7'b1011110;
  localparam logic [6:0] SEG_E     = 7'b1111001;
  localparam logic [6:0] SEG_F     = 7'b1110001;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    UPDATE
  } disp_state_e;

  function automatic glyph_e nibble_glyph(input logic [3:0] nib);
    return glyph_e'({1'b0, nib});
  endfunction

endpackage

// File: rtl/seg7_glyph.sv
// rtl/seg7_glyph.sv - combinational glyph code to active-high segment pattern
module seg7_glyph
  import seg7_pkg::*;
(
  input  glyph_e     glyph,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (glyph)
      GLYPH_0:     seg = SEG_0;
      GLYPH_1:     seg = SEG_1;
      GLYPH_2:     seg = SEG_2;
      GLYPH_3:     seg = SEG_3;
      GLYPH_4:     seg = SEG_4;
      GLYPH_5:     seg = SEG_5;
      GLYPH_6:     seg = SEG_6;
      GLYPH_7:     seg = SEG_7;
      GLYPH_8:     seg = SEG_8;
      GLYPH_9:     seg = SEG_9;
      GLYPH_A:     seg = SEG_A;
      GLYPH_B:     seg = SEG_B;
      GLYPH_C:     seg = SEG_C;
      GLYPH_D:     seg = SEG_D;
      GLYPH_E:     seg = SEG_E;
      GLYPH_F:     seg = SEG_F;
      GLYPH_DASH:  seg = SEG_DASH;
      GLYPH_BLANK: seg = SEG_BLANK;
      default:     seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_multi_display.sv
// rtl/seg7_multi_display.sv - multi-digit decimal/hex 7-segment controller with sequential double-dabble
module seg7_multi_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 20,
  parameter bit ACTIVE_LOW = 1'b1
)
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [DATA_W-1:0]       data_in,
  input  logic                    hex_mode,
  input  logic                    blank_zeros,
  output logic                    ready,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] leds
);

  localparam int          BCD_W     = 4 * NUM_DIGITS;
  localparam int          CNT_W     = $clog2(DATA_W + 1);
  localparam logic [6:0]  BLANK_PIX = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [63:0] DEC_MAX   = 64'(10 ** NUM_DIGITS) - 64'd1;

  disp_state_e       state;
  logic [DATA_W-1:0] bin_reg;
  logic [BCD_W-1:0]  bcd_reg;
  logic [CNT_W-1:0]  cnt;
  logic              hex_q;
  logic              blank_q;
  logic              ovf_q;

  // Overflow is decided on the raw input so the conversion never has to report it.
  logic [63:0] data_ext;
  logic        ovf_capture;
  assign data_ext    = 64'(data_in);
  assign ovf_capture = hex_mode ? ((data_ext >> BCD_W) != 64'd0) : (data_ext > DEC_MAX);

  logic [BCD_W-1:0]        bcd_adj;
  logic [BCD_W+DATA_W-1:0] dd_next;

  always_comb begin
    bcd_adj = bcd_reg;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_reg[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_reg[4*k +: 4] + 4'd3;
      end
    end
  end

  assign dd_next = {bcd_adj, bin_reg} << 1;

  logic [63:0]      bin_ext;
  logic [BCD_W-1:0] digit_src;
  assign bin_ext   = 64'(bin_reg);
  assign digit_src = hex_q ? bin_ext[BCD_W-1:0] : bcd_reg;

  // Walk from the top digit down; leading stays set until the first nonzero nibble.
  glyph_e     glyph [NUM_DIGITS];
  logic       leading;
  logic [3:0] nib;

  always_comb begin
    leading = blank_q;
    nib     = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      glyph[k] = GLYPH_BLANK;
    end
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      nib = digit_src[4*k +: 4];
      if (nib != 4'd0) begin
        leading = 1'b0;
      end
      if (ovf_q) begin
        glyph[k] = GLYPH_DASH;
      end else if (leading && (k != 0)) begin
        glyph[k] = GLYPH_BLANK;
      end else begin
        glyph[k] = nibble_glyph(nib);
      end
    end
  end

  logic [6:0] pix [NUM_DIGITS];

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    seg7_glyph u_glyph (
      .glyph (glyph[g]),
      .seg   (pix[g])
    );
  end

  logic [7*NUM_DIGITS-1:0] leds_next;

  always_comb begin
    leds_next = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      leds_next[7*k +: 7] = ACTIVE_LOW ? ~pix[k] : pix[k];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ready    <= 1'b1;
      overflow <= 1'b0;
      leds     <= {NUM_DIGITS{BLANK_PIX}};
      bin_reg  <= '0;
      bcd_reg  <= '0;
      cnt      <= '0;
      hex_q    <= 1'b0;
      blank_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            bin_reg <= data_in;
            bcd_reg <= '0;
            hex_q   <= hex_mode;
            blank_q <= blank_zeros;
            ovf_q   <= ovf_capture;
            cnt     <= CNT_W'(DATA_W);
            ready   <= 1'b0;
            state   <= hex_mode ? UPDATE : CONVERT;
          end
        end
        CONVERT: begin
          bcd_reg <= dd_next[BCD_W+DATA_W-1 -: BCD_W];
          bin_reg <= dd_next[DATA_W-1:0];
          cnt     <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= UPDATE;
          end
        end
        UPDATE: begin
          leds     <= leds_next;
          overflow <= ovf_q;
          ready    <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg7_multi_display.sv
// tb/tb_seg7_multi_display.sv - scoreboard bench for seg7_multi_display (6 digits, 20-bit, active-low)
module tb_seg7_multi_display;

  localparam int ND = 6;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          hex_mode = 1'b0;
  logic          blank_zeros = 1'b0;
  logic          ready;
  logic          overflow;
  logic [7*ND-1:0] leds;

  seg7_multi_display #(.NUM_DIGITS(ND), .DATA_W(DW), .ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .data_in     (data_in),
    .hex_mode    (hex_mode),
    .blank_zeros (blank_zeros),
    .ready       (ready),
    .overflow    (overflow),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7*ND-1:0] leds;
    logic            ovf;
  } exp_t;

  exp_t sb [$];
  int   n_checks = 0;
  int   n_pass   = 0;

  localparam logic [6:0] GLYPH_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic model_ovf(input logic [DW-1:0] v, input bit hx);
    return hx ? 1'b0 : (v > 20'd999999);
  endfunction

  function automatic logic [7*ND-1:0] model_leds(input logic [DW-1:0] v, input bit hx, input bit bz);
    int unsigned base;
    int unsigned x;
    int          d [ND];
    int          msd;
    logic [6:0]  pat;
    logic [7*ND-1:0] res;
    base = hx ? 16 : 10;
    x    = v;
    msd  = 0;
    res  = '0;
    for (int k = 0; k < ND; k++) begin
      d[k] = int'(x % base);
      x    = x / base;
      if (d[k] != 0) msd = k;
    end
    for (int k = 0; k < ND; k++) begin
      if (model_ovf(v, hx)) pat = 7'h40;
      else if (bz && k > msd) pat = 7'h00;
      else pat = GLYPH_TBL[d[k]];
      res[7*k +: 7] = ~pat;
    end
    return res;
  endfunction

  task automatic run_load(input logic [DW-1:0] v, input bit hx, input bit bz,
                          input logic [7*ND-1:0] e_leds, input bit e_ovf,
                          input int lat, input int glitch_at);
    logic [7*ND-1:0] prev;
    int   edges;
    bit   held;
    exp_t e;
    @(negedge clk);
    prev        = leds;
    load        = 1'b1;
    data_in     = v;
    hex_mode    = hx;
    blank_zeros = bz;
    sb.push_back('{leds: e_leds, ovf: e_ovf});
    @(posedge clk); #1;
    edges   = 1;
    load    = 1'b0;
    data_in = DW'($urandom);
    check("accept_ready_low", {63'd0, ready}, 64'd0);
    held = 1'b1;
    while (!ready && edges < 100) begin
      if (edges == glitch_at) begin
        load     = 1'b1;
        data_in  = 20'd777;
        hex_mode = 1'b1;
      end else begin
        load = 1'b0;
      end
      @(posedge clk); #1;
      edges++;
      if (!ready && leds !== prev) held = 1'b0;
    end
    load = 1'b0;
    check("latency", 64'(edges), 64'(lat));
    check("hold_during_convert", {63'd0, held}, 64'd1);
    e = sb.pop_front();
    check("leds", 64'(leds), 64'(e.leds));
    check("overflow", {63'd0, overflow}, {63'd0, e.ovf});
  endtask

  initial begin
    logic [DW-1:0] rv;
    bit            rh;
    bit            rb;

    repeat (2) @(posedge clk);
    #1;
    check("reset_leds", 64'(leds), 64'({ND{7'h7F}}));
    check("reset_ready", {63'd0, ready}, 64'd1);
    check("reset_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    run_load(20'd12345, 1'b0, 1'b1, {7'h7F, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b0, 22, 0);
    run_load(20'd12345, 1'b0, 1'b0, {7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12}, 1'b0, 22, 0);
    run_load(20'hFFFFF, 1'b0, 1'b1, {ND{7'h3F}}, 1'b1, 22, 0);

    // Abort a conversion with an asynchronous reset while overflow is still set.
    @(negedge clk);
    load        = 1'b1;
    data_in     = 20'd12345;
    hex_mode    = 1'b0;
    blank_zeros = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_leds", 64'(leds), 64'({ND{7'h7F}}));
    check("async_reset_ready", {63'd0, ready}, 64'd1);
    check("async_reset_overflow", {63'd0, overflow}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_ready", {63'd0, ready}, 64'd1);
    check("post_reset_leds", 64'(leds), 64'({ND{7'h7F}}));

    run_load(20'd42, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0, 22, 0);
    run_load(20'd999999, 1'b0, 1'b1, {ND{7'h10}}, 1'b0, 22, 0);
    run_load(20'hABCDE, 1'b1, 1'b1, {7'h7F, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06}, 1'b0, 2, 0);
    run_load(20'd0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 22, 0);
    run_load(20'd54321, 1'b0, 1'b0, {7'h40, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79}, 1'b0, 22, 5);
    run_load(20'h00000, 1'b1, 1'b0, {ND{7'h40}}, 1'b0, 2, 0);

    for (int i = 0; i < 8; i++) begin
      rv = DW'($urandom) >> $urandom_range(0, 19);
      rh = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      run_load(rv, rh, rb, model_leds(rv, rh, rb), model_ovf(rv, rh), rh ? 2 : 22, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
